camera_controller: RTL and testbench
====================================

CAMERA_CONTROLLER -- requirements
Module: camera_controller

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 33, cycles key/cnt are held stable before load (at least the FP pipeline latency, multiple of 3).
REQ-002 SHALL have parameter CNT_MAX, default 64, saturation value of the hold counter.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, button synchronizer depth.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 btn  input  6  raw async buttons; index i = move code i (0 U+,1 U-,2 V+,3 V-,4 W+,5 W-).
REQ-007 frame_done  input  1  one-cycle pulse at end of each rendered frame.
REQ-008 v0, v1, v2  output  1 each  one-hot phase strobes to the camera datapath.
REQ-009 key  output  3  selected move code.
REQ-010 cnt  output  32  move magnitude (unsigned integer).
REQ-011 ld_curr_camera  output  1  commit request to the datapath.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Phase generator SHALL rotate v0->v1->v2->v0 every cycle, free-running, exactly one strobe high.
REQ-014 Buttons SHALL pass through a SYNC_STAGES-flop synchronizer before any use.
REQ-015 Arbiter SHALL select the lowest asserted synchronized btn index; key = that index in 3-bit binary.
REQ-016 FSM states SHALL be IDLE, ARM, RUN, LOAD.
REQ-017 IDLE: on frame_done with any btn asserted, latch key and cnt, go to ARM next cycle.
REQ-018 ARM: wait; transition to RUN at the edge where v2=1, so RUN starts on a v0 cycle.
REQ-019 RUN: count SETTLE_CYC cycles; then LOAD.
REQ-020 LOAD: assert ld_curr_camera for exactly 3 cycles (one full v0/v1/v2 rotation), then IDLE.
REQ-021 key and cnt SHALL remain constant from ARM entry until return to IDLE.
REQ-022 frame_done outside IDLE SHALL be ignored (not queued).
REQ-023 Hold counter: on each frame_done, +1 (saturate at CNT_MAX) if the same winner as the previous frame is held; reset to 1 if the winner changed; cleared to 0 if no btn held.
REQ-024 Button release during ARM/RUN/LOAD SHALL NOT abort; update completes with latched values.
REQ-025 With no btn asserted, ld_curr_camera SHALL never assert.

Reset
REQ-026 On rst: v0=1, v1=0, v2=0, key=0, cnt=0, ld_curr_camera=0, busy=0, state IDLE, hold counter 0, synchronizer flops 0.
REQ-027 rst mid-operation SHALL abandon the update immediately; no ld_curr_camera pulse after rst release until a new frame_done with a held btn.

Configuration
REQ-028 Macro CAM_ACCEL_EN defined: cnt latched = post-increment hold counter value (acceleration while held).
REQ-029 CAM_ACCEL_EN undefined: cnt latched = 1 always; hold counter logic SHALL be absent.

Structure
REQ-030 Shared package cam_pkg SHALL hold the key code constants (UPOS..WNEG), the FSM state enum, and the default SETTLE_CYC/CNT_MAX values.
REQ-031 Synchronizer SHALL be sub-module cam_btn_sync (parameterized width and depth); the arbiter, FSM and phase generator stay in camera_controller.

Verification
REQ-032 Reset release -> v0,v1,v2 = 100,010,001,100...; all other outputs 0.
REQ-033 btn=6'b000100 held, one frame_done -> key=3'b010, cnt=1, busy rises next cycle, ld_curr_camera high for exactly 3 cycles after SETTLE_CYC RUN cycles, RUN entered on a v0 cycle.
REQ-034 btn=6'b100010 -> key=3'b001 (lowest index wins).
REQ-035 CAM_ACCEL_EN, btn0 held across 70 frames -> cnt values 1,2,3,... saturating at 64; change to btn2 -> cnt=1.
REQ-036 frame_done pulses during RUN -> no additional update; button released in RUN -> ld_curr_camera still pulses with original key/cnt.
REQ-037 rst asserted during LOAD -> ld_curr_camera drops asynchronously; outputs return to reset values.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera controller: move codes, FSM states and
// default timing/saturation values.
package cam_pkg;

    // Move codes, one per button index
    localparam logic [2:0] UPOS = 3'd0;
    localparam logic [2:0] UNEG = 3'd1;
    localparam logic [2:0] VPOS = 3'd2;
    localparam logic [2:0] VNEG = 3'd3;
    localparam logic [2:0] WPOS = 3'd4;
    localparam logic [2:0] WNEG = 3'd5;

    // Default settle time (FP pipeline latency, multiple of 3) and hold saturation
    localparam int SETTLE_CYC_DEF = 33;
    localparam int CNT_MAX_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        LOAD = 2'd3
    } cam_state_t;

endpackage

// File: rtl/cam_btn_sync.sv
// Multi-stage synchronizer for a vector of asynchronous button inputs.
module cam_btn_sync #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift the raw buttons through DEPTH flops to resolve metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/camera_controller.sv
// Camera move controller: synchronizes buttons, picks the winning move on a
// frame boundary and sequences a phase-aligned commit to the camera datapath.
// Optional macro CAM_ACCEL_EN: the move magnitude follows a per-frame hold
// counter (acceleration while a button is held); otherwise it is always 1.
module camera_controller
    import cam_pkg::*;
#(
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int CNT_MAX     = CNT_MAX_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  btn,
    input  logic        frame_done,
    output logic        v0,
    output logic        v1,
    output logic        v2,
    output logic [2:0]  key,
    output logic [31:0] cnt,
    output logic        ld_curr_camera,
    output logic        busy
);

    logic [5:0]  btn_s;
    logic        any_btn;
    logic [2:0]  win_key;
    logic [2:0]  phase;
    logic [31:0] step_cnt;
    logic [31:0] cnt_sel;
    logic        start;
    cam_state_t  state, state_next;

    cam_btn_sync #(
        .WIDTH (6),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn),
        .dout (btn_s)
    );

    assign any_btn = |btn_s;
    assign start   = frame_done && any_btn;

    // Free-running one-hot phase rotation v0 -> v1 -> v2 -> v0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= 3'b001;
        else     phase <= {phase[1:0], phase[2]};
    end

    assign v0 = phase[0];
    assign v1 = phase[1];
    assign v2 = phase[2];

    // Lowest asserted button index wins
    always_comb begin
        win_key = UPOS;
        if      (btn_s[UPOS]) win_key = UPOS;
        else if (btn_s[UNEG]) win_key = UNEG;
        else if (btn_s[VPOS]) win_key = VPOS;
        else if (btn_s[VNEG]) win_key = VNEG;
        else if (btn_s[WPOS]) win_key = WPOS;
        else if (btn_s[WNEG]) win_key = WNEG;
    end

`ifdef CAM_ACCEL_EN
    logic [31:0] hold_cnt, hold_next;
    logic [2:0]  prev_key;

    // Next hold value: grow while the same winner stays held, restart on change
    always_comb begin
        hold_next = 32'd0;
        if (any_btn) begin
            if (hold_cnt != 32'd0 && win_key == prev_key) begin
                if (hold_cnt >= 32'(CNT_MAX)) hold_next = 32'(CNT_MAX);
                else                          hold_next = hold_cnt + 32'd1;
            end else begin
                hold_next = 32'd1;
            end
        end
    end

    // Hold counter advances once per rendered frame, whatever the FSM is doing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 32'd0;
            prev_key <= 3'd0;
        end else if (frame_done) begin
            hold_cnt <= hold_next;
            prev_key <= win_key;
        end
    end

    assign cnt_sel = hold_next;
`else
    assign cnt_sel = 32'd1;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and commit decode; frame_done is only honoured in IDLE
    always_comb begin
        state_next     = state;
        ld_curr_camera = 1'b0;
        case (state)
            IDLE: if (start) state_next = ARM;
            ARM:  if (v2) state_next = RUN;
            RUN:  if (step_cnt == 32'(SETTLE_CYC - 1)) state_next = LOAD;
            LOAD: begin
                ld_curr_camera = 1'b1;
                if (step_cnt == 32'd2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Per-state cycle counter, restarted on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       step_cnt <= 32'd0;
        else if (state_next != state || state == IDLE) step_cnt <= 32'd0;
        else                                           step_cnt <= step_cnt + 32'd1;
    end

    // Capture move code and magnitude when an update is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key <= 3'd0;
            cnt <= 32'd0;
        end else if (state == IDLE && start) begin
            key <= win_key;
            cnt <= cnt_sel;
        end
    end

endmodule

// File: tb/tb_camera_controller.sv
// Self-checking bench for camera_controller. Expected move code/magnitude are
// queued when a frame_done is issued and compared when ld_curr_camera fires.
// Honours CAM_ACCEL_EN for the expected magnitude.
module tb_camera_controller;

    localparam int SETTLE  = 33;
    localparam int CMAX    = 64;
    localparam int NSYNC   = 2;

    typedef struct packed {
        logic [2:0]  key;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  btn;
    logic        frame_done;
    logic        v0, v1, v2;
    logic [2:0]  key;
    logic [31:0] cnt;
    logic        ld_curr_camera;
    logic        busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   hold     = 0;
    int   prev_win = 0;
    logic [2:0] ph_model;

    camera_controller #(
        .SETTLE_CYC  (SETTLE),
        .CNT_MAX     (CMAX),
        .SYNC_STAGES (NSYNC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn            (btn),
        .frame_done     (frame_done),
        .v0             (v0),
        .v1             (v1),
        .v2             (v2),
        .key            (key),
        .cnt            (cnt),
        .ld_curr_camera (ld_curr_camera),
        .busy           (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Reference phase rotation ordered {v0,v1,v2}
    always @(posedge clk or posedge rst) begin
        if (rst) ph_model <= 3'b100;
        else     ph_model <= {ph_model[0], ph_model[2:1]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int winner(input logic [5:0] b);
        for (int i = 0; i < 6; i++) if (b[i]) return i;
        return 0;
    endfunction

    function automatic void holdUpdate(input logic [5:0] b);
        int w;
        if (b == 6'd0) begin
            hold = 0;
        end else begin
            w = winner(b);
            if (hold != 0 && w == prev_win) hold = (hold >= CMAX) ? CMAX : hold + 1;
            else                            hold = 1;
            prev_win = w;
        end
    endfunction

    function automatic logic [31:0] expCnt();
`ifdef CAM_ACCEL_EN
        return 32'(hold);
`else
        return 32'd1;
`endif
    endfunction

    // Set buttons, let them synchronize, then issue one frame_done pulse
    task automatic applyStimulus(input logic [5:0] b);
        exp_t e;
        @(negedge clk);
        btn = b;
        repeat (NSYNC + 1) @(negedge clk);
        frame_done = 1'b1;
        holdUpdate(b);
        e.key = 3'(winner(b));
        e.cnt = expCnt();
        if (b != 6'd0) sb.push_back(e);
        @(negedge clk);
        frame_done = 1'b0;
        checkOutput("busy_rise", busy, (b != 6'd0));
        if (b != 6'd0) begin
            checkOutput("latch_key", key, e.key);
            checkOutput("latch_cnt", cnt, e.cnt);
        end
    endtask

    // Follow one accepted update to completion; optionally release the button
    // and pulse frame_done while in RUN
    task automatic runUpdate(input bit release_in_run);
        int   n;
        int   arm_len;
        int   ldc;
        exp_t e;
        arm_len = (ph_model == 3'b100) ? 3 : (ph_model == 3'b010) ? 2 : 1;
        n = 1;
        while (ld_curr_camera !== 1'b1 && n < 200) begin
            if (release_in_run) begin
                case (n)
                    10: btn = 6'd0;
                    14: begin frame_done = 1'b1; holdUpdate(6'd0); end
                    15: frame_done = 1'b0;
                    18: begin frame_done = 1'b1; holdUpdate(6'd0); end
                    19: frame_done = 1'b0;
                    default: ;
                endcase
            end
            @(negedge clk);
            if (ld_curr_camera !== 1'b1) n++;
        end
        if (n >= 200) begin
            checkOutput("ld_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("run_len", n, arm_len + SETTLE);
        checkOutput("ld_on_v0", {v0, v1, v2}, 3'b100);
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("ld_key", key, e.key);
            checkOutput("ld_cnt", cnt, e.cnt);
        end
        ldc = 0;
        while (ld_curr_camera === 1'b1 && ldc < 10) begin
            ldc++;
            @(negedge clk);
        end
        checkOutput("ld_len", ldc, 3);
        checkOutput("idle_after", busy, 0);
    endtask

    // Count ld_curr_camera cycles over a quiet window
    task automatic expectNoLoad(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ld_curr_camera === 1'b1) seen++;
        end
        checkOutput(tag, seen, 0);
    endtask

    initial begin
        int waitc;
        rst = 1'b1;
        btn = 6'd0;
        frame_done = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_phase", {v0, v1, v2}, 3'b100);
        checkOutput("rst_key", key, 0);
        checkOutput("rst_cnt", cnt, 0);
        checkOutput("rst_ld", ld_curr_camera, 0);
        checkOutput("rst_busy", busy, 0);

        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("phase_rot", {v0, v1, v2}, ph_model);
        end
        checkOutput("idle_outs", {key, cnt, ld_curr_camera, busy}, 0);

        // Single button, then two buttons where the lower index wins
        applyStimulus(6'b000100);
        runUpdate(1'b0);
        applyStimulus(6'b100010);
        runUpdate(1'b0);

        // frame_done with nothing held must not start an update
        applyStimulus(6'b000000);
        expectNoLoad("no_btn_ld", 40);

        // Long hold on U+ then a change of winner
        for (int f = 0; f < 70; f++) begin
            applyStimulus(6'b000001);
            runUpdate(1'b0);
        end
        applyStimulus(6'b000100);
        runUpdate(1'b0);

        // Release and extra frame_done pulses during RUN
        applyStimulus(6'b001000);
        runUpdate(1'b1);
        expectNoLoad("no_extra_ld", 60);

        // Reset in the middle of LOAD
        applyStimulus(6'b010000);
        waitc = 0;
        while (ld_curr_camera !== 1'b1 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("rst_ld_reached", ld_curr_camera, 1);
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b1;
        hold = 0;
        #1;
        checkOutput("async_ld_drop", ld_curr_camera, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_phase", {v0, v1, v2}, 3'b100);
        checkOutput("async_key", key, 0);
        checkOutput("async_cnt", cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        expectNoLoad("post_rst_ld", 60);
        applyStimulus(6'b010000);
        runUpdate(1'b0);

        checkOutput("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
